// File: rtl/fpadd_pkg.sv
// Shared types/constants for the FP adder arbiter.
// NREQ requesters, SEL_W-bit select, FSM state encodings.
package fpadd_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic logic [NREQ-1:0] onehot(
    input logic [SEL_W-1:0] i
  );
    return NREQ'(1) << i;
  endfunction

endpackage

// File: rtl/fpadd_arbiter_if.sv
// Requester/adder handshake bundle for fpadd_arbiter.
// master: requesters + adder side; slave: the arbiter.
interface fpadd_arbiter_if;
  import fpadd_pkg::*;

  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [SEL_W-1:0] sel;
  logic             start;
  logic             add_done;
  logic [NREQ-1:0]  rsp_valid;
  logic             busy;
  logic             timeout;

  modport master (
    output req_valid, add_done,
    input  req_ready, sel, start,
    input  rsp_valid, busy, timeout
  );

  modport slave (
    input  req_valid, add_done,
    output req_ready, sel, start,
    output rsp_valid, busy, timeout
  );

endinterface

// File: rtl/fpadd_rr_pick.sv
// Rotating priority pick: first set bit of req at or
// after ptr (mod NREQ). Ports: req, ptr -> idx, any.
module fpadd_rr_pick
  import fpadd_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] j;

  // Scan from the farthest offset down so the
  // closest set bit to ptr is the last write.
  always_comb begin
    idx = '0;
    j   = '0;
    any = |req;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = ptr + SEL_W'(i);
      if (req[j]) idx = j;
    end
  end

endmodule

// File: rtl/fpadd_arbiter.sv
// Arbiter sharing one FP adder among NREQ requesters.
// Ports: clk, rst_n, bus (fpadd_arbiter_if.slave).
// Build macro FPADD_ARB_FIXED_PRIO_EN: fixed priority,
// index 0 highest; otherwise round-robin.
module fpadd_arbiter
  import fpadd_pkg::*;
#(
  parameter int MAX_WAIT = 15
)(
  input  logic            clk,
  input  logic            rst_n,
  fpadd_arbiter_if.slave  bus
);

  state_t state, state_nx;

  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic [CNT_W-1:0] cnt;

  logic [NREQ-1:0]  ready_d, ready_q;
  logic [NREQ-1:0]  rsp_d, rsp_q;
  logic             start_d, start_q;
  logic             tmo_d, tmo_q;

  logic issue_ok;
  logic done;
  logic expire;

  assign issue_ok = bus.req_valid[grant];
  assign done     = bus.add_done;
  // Count reaches MAX_WAIT on this edge.
  assign expire   = cnt == CNT_W'(MAX_WAIT - 1);

  fpadd_rr_pick u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pick_any) state_nx = ISSUE;
      ISSUE:   state_nx = issue_ok ? WAIT : IDLE;
      WAIT: begin
        if (done)        state_nx = RESP;
        else if (expire) state_nx = IDLE;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Pulse outputs are registered: they appear in
  // the cycle after the decision, aligned with the
  // state that the decision moves into.
  always_comb begin
    ready_d = '0;
    start_d = 1'b0;
    rsp_d   = '0;
    tmo_d   = 1'b0;
    unique case (state)
      ISSUE: begin
        if (issue_ok) begin
          ready_d = onehot(grant);
          start_d = 1'b1;
        end
      end
      WAIT: begin
        if (done)        rsp_d = onehot(grant);
        else if (expire) tmo_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant   <= '0;
      cnt     <= '0;
      ready_q <= '0;
      start_q <= 1'b0;
      rsp_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      ready_q <= ready_d;
      start_q <= start_d;
      rsp_q   <= rsp_d;
      tmo_q   <= tmo_d;
      if (state == IDLE && pick_any)
        grant <= pick_idx;
      if (state == ISSUE)
        cnt <= '0;
      else if (state == WAIT && !done)
        cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef FPADD_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (state == RESP || tmo_d)
      rr_ptr <= grant + SEL_W'(1);
  end
`endif

  assign bus.sel       = grant;
  assign bus.req_ready = ready_q;
  assign bus.start     = start_q;
  assign bus.rsp_valid = rsp_q;
  assign bus.timeout   = tmo_q;
  assign bus.busy      = state != IDLE;

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Randomized self-checking bench for fpadd_arbiter.
// Transaction-level model of grant order and timing.
module tb_fpadd_arbiter;

  localparam int MAX_WAIT = 15;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  int   rr;

  fpadd_arbiter_if bus ();

  fpadd_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [3:0] m,
                              input int ptr);
    int p;
    int idx;
`ifdef FPADD_ARB_FIXED_PRIO_EN
    p = 0;
`else
    p = ptr;
`endif
    for (int off = 0; off < 4; off++) begin
      idx = (p + off) % 4;
      if (m[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic int next_ptr(input int g);
`ifdef FPADD_ARB_FIXED_PRIO_EN
    return 0;
`else
    return (g + 1) % 4;
`endif
  endfunction

  // mode 0: add_done k cycles after start
  // mode 1: no add_done, expect timeout
  // mode 2: granted request withdrawn in ISSUE
  task automatic run_txn(input logic [3:0] mask,
                         input int mode,
                         input int k,
                         input bit stray);
    int g;
    logic [3:0] oh;
    g  = pick(mask, rr);
    oh = 4'(1 << g);
    chk("idle_busy", 32'(bus.busy), 0);
    bus.req_valid = mask;
    tick();
    chk("issue_sel", 32'(bus.sel), 32'(g));
    chk("issue_busy", 32'(bus.busy), 1);
    chk("issue_start", 32'(bus.start), 0);
    if (stray) bus.add_done = 1'b1;
    if (mode == 2) begin
      bus.req_valid = '0;
      tick();
      bus.add_done = 1'b0;
      chk("wd_start", 32'(bus.start), 0);
      chk("wd_ready", 32'(bus.req_ready), 0);
      chk("wd_busy", 32'(bus.busy), 0);
      return;
    end
    tick();
    bus.add_done = 1'b0;
    chk("start", 32'(bus.start), 1);
    chk("ready", 32'(bus.req_ready), 32'(oh));
    chk("sel", 32'(bus.sel), 32'(g));
    bus.req_valid = '0;
    if (mode == 0) begin
      repeat (k) begin
        tick();
        chk("wait_start", 32'(bus.start), 0);
        chk("wait_rsp", 32'(bus.rsp_valid), 0);
        chk("wait_tmo", 32'(bus.timeout), 0);
      end
      bus.add_done = 1'b1;
      tick();
      bus.add_done = 1'b0;
      chk("rsp", 32'(bus.rsp_valid), 32'(oh));
      chk("rsp_busy", 32'(bus.busy), 1);
      chk("rsp_sel", 32'(bus.sel), 32'(g));
      tick();
      chk("post_rsp", 32'(bus.rsp_valid), 0);
      chk("post_busy", 32'(bus.busy), 0);
    end else begin
      repeat (MAX_WAIT - 1) begin
        tick();
        chk("pre_tmo", 32'(bus.timeout), 0);
        chk("pre_tmo_rsp", 32'(bus.rsp_valid), 0);
        chk("pre_tmo_busy", 32'(bus.busy), 1);
      end
      tick();
      chk("tmo", 32'(bus.timeout), 1);
      chk("tmo_rsp", 32'(bus.rsp_valid), 0);
      chk("tmo_busy", 32'(bus.busy), 0);
    end
    rr = next_ptr(g);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready), 0);
    chk({tag, "_start"}, 32'(bus.start), 0);
    chk({tag, "_rsp"}, 32'(bus.rsp_valid), 0);
    chk({tag, "_tmo"}, 32'(bus.timeout), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_sel"}, 32'(bus.sel), 0);
  endtask

  initial begin
    int mode;
    n_chk = 0;
    n_err = 0;
    rr    = 0;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.add_done  = 1'b0;
    #3;
    chk_all_zero("rst");
    tick();
    tick();
    rst_n = 1'b1;

    // Single requester, k=3: start c2, rsp c6, idle c7.
    run_txn(4'b0001, 0, 3, 0);

    // All requesters held: rotating grants.
    for (int i = 0; i < 5; i++)
      run_txn(4'b1111, 0, $urandom_range(1, 6), 0);

    // Timeout, then next grant follows.
    run_txn(4'b0100, 1, 0, 0);
    run_txn(4'b1111, 0, 2, 0);

    // Withdraw in ISSUE; pointer must not move.
    run_txn(4'b0100, 2, 0, 0);
    run_txn(4'b1111, 0, 1, 0);

    // add_done on the last cycle before expiry.
    run_txn(4'b0010, 0, MAX_WAIT - 1, 0);

    // Stray add_done in IDLE.
    bus.add_done = 1'b1;
    tick();
    bus.add_done = 1'b0;
    chk("stray_busy", 32'(bus.busy), 0);
    chk("stray_rsp", 32'(bus.rsp_valid), 0);
    tick();
    chk("stray_rsp2", 32'(bus.rsp_valid), 0);
    chk("stray_busy2", 32'(bus.busy), 0);

    // Reset during WAIT with sel=3.
    bus.req_valid = 4'b1000;
    tick();
    tick();
    bus.req_valid = '0;
    chk("rw_sel", 32'(bus.sel), 3);
    chk("rw_start", 32'(bus.start), 1);
    tick();
    chk("rw_busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rr = 0;
    bus.add_done = 1'b1;
    tick();
    bus.add_done = 1'b0;
    chk("arst_rsp", 32'(bus.rsp_valid), 0);
    tick();
    chk("arst_rsp2", 32'(bus.rsp_valid), 0);
    chk("arst_busy", 32'(bus.busy), 0);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 99);
      mode = (mode < 70) ? 0 : (mode < 85) ? 1 : 2;
      run_txn(4'($urandom_range(1, 15)), mode,
              $urandom_range(1, 6),
              1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
